// File: rtl/ddfs_phase_accumulator.sv
// Prescaled DDFS phase accumulator with staged frequency-word updates.
// New parameters take effect only at a prescaler boundary to keep phase continuous.
module ddfs_phase_accumulator #(
   parameter int ACC_WIDTH = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en,
   input  logic [6:0]           fw,
   input  logic [2:0]           freq_control,
   input  logic                 update,
   output logic [ACC_WIDTH-1:0] phase,
   output logic                 tick,
   output logic                 wrap,
   output logic                 pending
);

   localparam int SW = ACC_WIDTH + 1;

   logic [6:0]           r_a_fw;
   logic [2:0]           r_a_fc;
   logic [6:0]           r_s_fw;
   logic [2:0]           r_s_fc;
   logic [19:0]          r_pc;
   logic [ACC_WIDTH-1:0] r_phase;
   logic                 r_tick;
   logic                 r_wrap;
   logic                 r_pend;

   logic [19:0]          w_last;
   logic                 w_tc;
   logic [SW-1:0]        w_sum;

   // Terminal count value N-1 for the active decade; code 7 aliases to /2
   always_comb begin
      w_last = 20'd1;
      unique case (r_a_fc)
         3'd1:    w_last = 20'd9;
         3'd2:    w_last = 20'd99;
         3'd3:    w_last = 20'd999;
         3'd4:    w_last = 20'd9999;
         3'd5:    w_last = 20'd99999;
         3'd6:    w_last = 20'd999999;
         default: w_last = 20'd1;
      endcase
   end

   assign w_tc  = en && (r_pc == w_last);
   assign w_sum = SW'(r_phase) + SW'(r_a_fw) + SW'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a_fw  <= '0;
         r_a_fc  <= '0;
         r_s_fw  <= '0;
         r_s_fc  <= '0;
         r_pc    <= '0;
         r_phase <= '0;
         r_tick  <= 1'b0;
         r_wrap  <= 1'b0;
         r_pend  <= 1'b0;
      end else if (en) begin
         if (w_tc) begin
            r_pc    <= '0;
            r_phase <= w_sum[ACC_WIDTH-1:0];
            r_wrap  <= w_sum[ACC_WIDTH];
            r_tick  <= 1'b1;
            r_pend  <= 1'b0;
            // Advance above still uses the old step; new values govern the next period
            if (update) begin
               r_a_fw <= fw;
               r_a_fc <= freq_control;
            end else if (r_pend) begin
               r_a_fw <= r_s_fw;
               r_a_fc <= r_s_fc;
            end
         end else begin
            r_pc   <= r_pc + 20'd1;
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
            if (update) begin
               r_s_fw <= fw;
               r_s_fc <= freq_control;
               r_pend <= 1'b1;
            end
         end
      end else begin
         r_tick <= 1'b0;
         r_wrap <= 1'b0;
         // Stopped: apply immediately and restart the prescaler period
         if (update || r_pend) begin
            r_pc   <= '0;
            r_pend <= 1'b0;
         end
         if (update) begin
            r_a_fw <= fw;
            r_a_fc <= freq_control;
         end else if (r_pend) begin
            r_a_fw <= r_s_fw;
            r_a_fc <= r_s_fc;
         end
      end
   end

   assign phase   = r_phase;
   assign tick    = r_tick;
   assign wrap    = r_wrap;
   assign pending = r_pend;

endmodule

// File: tb/tb_ddfs_phase_accumulator.sv
// Self-checking bench for ddfs_phase_accumulator.
// Reference model tracks period length, step and elapsed clocks per period.
module tb_ddfs_phase_accumulator;

   localparam int AW     = 10;
   localparam int PERIOD = 1 << AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic [6:0]    fw;
   logic [2:0]    freq_control;
   logic          update;
   logic [AW-1:0] phase;
   logic          tick;
   logic          wrap;
   logic          pending;

   int n_chk = 0;
   int n_err = 0;

   logic [AW-1:0] m_ph;
   bit            m_tick, m_wrap, m_pend;
   int            m_cnt, m_n, m_step, s_n, s_step;

   always #5 clk = ~clk;

   ddfs_phase_accumulator #(.ACC_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .en(en), .fw(fw),
      .freq_control(freq_control), .update(update),
      .phase(phase), .tick(tick), .wrap(wrap), .pending(pending)
   );

   function automatic int ratio(input logic [2:0] c);
      case (c)
         3'd0: return 2;
         3'd1: return 10;
         3'd2: return 100;
         3'd3: return 1000;
         3'd4: return 10000;
         3'd5: return 100000;
         3'd6: return 1000000;
         default: return 2;
      endcase
   endfunction

   function automatic logic [AW+2:0] exp_vec();
      return {m_ph, m_tick, m_wrap, m_pend};
   endfunction

   task automatic model_reset();
      m_ph = '0; m_tick = 0; m_wrap = 0; m_pend = 0;
      m_cnt = 0; m_n = 2; m_step = 1; s_n = 2; s_step = 1;
   endtask

   task automatic model_edge(input bit e, input bit u,
                             input logic [6:0] f, input logic [2:0] c);
      int sum;
      m_tick = 0;
      m_wrap = 0;
      if (e) begin
         m_cnt++;
         if (m_cnt == m_n) begin
            sum = int'(m_ph) + m_step;
            m_wrap = (sum >= PERIOD);
            m_ph = AW'(sum % PERIOD);
            m_tick = 1;
            m_cnt = 0;
            if (u) begin
               m_step = int'(f) + 1; m_n = ratio(c); m_pend = 0;
            end else if (m_pend) begin
               m_step = s_step; m_n = s_n; m_pend = 0;
            end
         end else if (u) begin
            s_step = int'(f) + 1; s_n = ratio(c); m_pend = 1;
         end
      end else if (u) begin
         m_step = int'(f) + 1; m_n = ratio(c); m_pend = 0; m_cnt = 0;
      end else if (m_pend) begin
         m_step = s_step; m_n = s_n; m_pend = 0; m_cnt = 0;
      end
   endtask

   task automatic drive(input bit e, input bit u,
                        input logic [6:0] f, input logic [2:0] c);
      en = e; update = u; fw = f; freq_control = c;
      @(posedge clk);
      model_edge(e, u, f, c);
      #1;
      update = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b1; update = 1'b0; fw = '0; freq_control = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_chk++;
      if ({phase, tick, wrap, pending} !== '0) begin
         n_err++;
         $display("FAIL reset_state: got %h want 0", {phase, tick, wrap, pending});
      end
      rst = 1'b0;
   endtask

   task automatic test_default();
      int first_wrap = -1;
      for (int i = 1; i <= 2048; i++) begin
         drive(1, 0, 0, 0);
         n_chk++;
         if ({phase, tick, wrap, pending} !== exp_vec()) begin
            n_err++;
            $display("FAIL default c%0d: got %h want %h", i, {phase, tick, wrap, pending}, exp_vec());
         end
         if (i == 2) begin
            n_chk++;
            if (tick !== 1'b1 || phase !== 10'd1) begin
               n_err++;
               $display("FAIL first_tick: got t=%0b ph=%0d want t=1 ph=1", tick, phase);
            end
         end
         if (wrap === 1'b1 && first_wrap < 0) first_wrap = i;
      end
      n_chk++;
      if (first_wrap != 2048 || phase !== '0) begin
         n_err++;
         $display("FAIL default_wrap: got clk=%0d ph=%0d want clk=2048 ph=0", first_wrap, phase);
      end
   endtask

   task automatic test_en_low_update();
      int ticks = 0;
      drive(0, 1, 7'd127, 3'd1);
      n_chk++;
      if (pending !== 1'b0) begin
         n_err++;
         $display("FAIL enlow_pending: got %0b want 0", pending);
      end
      for (int i = 1; i <= 80; i++) begin
         drive(1, 0, 0, 0);
         ticks += int'(tick);
         n_chk++;
         if ({phase, tick, wrap, pending} !== exp_vec()) begin
            n_err++;
            $display("FAIL enlow c%0d: got %h want %h", i, {phase, tick, wrap, pending}, exp_vec());
         end
      end
      n_chk++;
      if (ticks != 8 || phase !== '0 || wrap !== 1'b1) begin
         n_err++;
         $display("FAIL div10_step128: got ticks=%0d ph=%0d w=%0b want 8 0 1", ticks, phase, wrap);
      end
   endtask

   task automatic test_midperiod_update();
      int pend_cyc = 0;
      int nt = 0;
      logic [AW-1:0] last;
      drive(0, 1, 7'd0, 3'd1);
      repeat (4) drive(1, 0, 0, 0);
      drive(1, 1, 7'd3, 3'd0);
      last = phase;
      pend_cyc += int'(pending);
      for (int i = 1; i <= 12; i++) begin
         drive(1, 0, 0, 0);
         pend_cyc += int'(pending);
         n_chk++;
         if ({phase, tick, wrap, pending} !== exp_vec()) begin
            n_err++;
            $display("FAIL midupd c%0d: got %h want %h", i, {phase, tick, wrap, pending}, exp_vec());
         end
         if (tick) begin
            nt++;
            n_chk++;
            if (phase - last !== ((nt == 1) ? 10'd1 : 10'd4)) begin
               n_err++;
               $display("FAIL midupd_step%0d: got %0d want %0d", nt, phase - last, (nt == 1) ? 1 : 4);
            end
            last = phase;
         end
      end
      n_chk++;
      if (pend_cyc != 5) begin
         n_err++;
         $display("FAIL midupd_pending_len: got %0d want 5", pend_cyc);
      end
   endtask

   task automatic test_update_on_tc();
      logic [AW-1:0] p0;
      bit saw_pend = 0;
      drive(0, 1, 7'd0, 3'd0);
      drive(1, 0, 0, 0);
      p0 = phase;
      drive(1, 1, 7'd9, 3'd0);
      saw_pend |= pending;
      n_chk++;
      if (tick !== 1'b1 || phase - p0 !== 10'd1) begin
         n_err++;
         $display("FAIL tcupd_first: got t=%0b d=%0d want t=1 d=1", tick, phase - p0);
      end
      p0 = phase;
      drive(1, 0, 0, 0);
      saw_pend |= pending;
      drive(1, 0, 0, 0);
      saw_pend |= pending;
      n_chk++;
      if (tick !== 1'b1 || phase - p0 !== 10'd10 || saw_pend) begin
         n_err++;
         $display("FAIL tcupd_second: got t=%0b d=%0d p=%0b want 1 10 0", tick, phase - p0, saw_pend);
      end
   endtask

   task automatic test_invalid_code();
      int ticks = 0;
      logic [AW-1:0] p0;
      drive(0, 1, 7'd0, 3'd7);
      p0 = phase;
      for (int i = 1; i <= 10; i++) begin
         drive(1, 0, 0, 0);
         ticks += int'(tick);
         n_chk++;
         if ({phase, tick, wrap, pending} !== exp_vec()) begin
            n_err++;
            $display("FAIL code7 c%0d: got %h want %h", i, {phase, tick, wrap, pending}, exp_vec());
         end
      end
      n_chk++;
      if (ticks != 5 || phase - p0 !== 10'd5) begin
         n_err++;
         $display("FAIL code7_rate: got ticks=%0d d=%0d want 5 5", ticks, phase - p0);
      end
   endtask

   task automatic test_en_pause();
      int ticks = 0;
      drive(0, 1, 7'd0, 3'd1);
      for (int i = 1; i <= 17; i++) begin
         drive((i <= 3) || (i > 10), 0, 0, 0);
         ticks += int'(tick);
         n_chk++;
         if ({phase, tick, wrap, pending} !== exp_vec()) begin
            n_err++;
            $display("FAIL pause c%0d: got %h want %h", i, {phase, tick, wrap, pending}, exp_vec());
         end
      end
      n_chk++;
      if (ticks != 1 || tick !== 1'b1) begin
         n_err++;
         $display("FAIL pause_ticks: got %0d last=%0b want 1 1", ticks, tick);
      end
   endtask

   task automatic test_random();
      bit e, u;
      logic [6:0] f;
      logic [2:0] c;
      for (int i = 1; i <= 3000; i++) begin
         e = ($urandom_range(0, 9) != 0);
         u = ($urandom_range(0, 24) == 0);
         f = 7'($urandom);
         c = 3'($urandom_range(0, 3));
         if (c == 3'd3) c = 3'd7;
         drive(e, u, f, c);
         n_chk++;
         if ({phase, tick, wrap, pending} !== exp_vec()) begin
            n_err++;
            $display("FAIL random c%0d: got %h want %h", i, {phase, tick, wrap, pending}, exp_vec());
         end
      end
   endtask

   task automatic test_reset_pending();
      drive(0, 1, 7'd0, 3'd1);
      repeat (3) drive(1, 0, 0, 0);
      drive(1, 1, 7'd50, 3'd0);
      n_chk++;
      if (pending !== 1'b1) begin
         n_err++;
         $display("FAIL rstpend_setup: got %0b want 1", pending);
      end
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      n_chk++;
      if ({phase, tick, wrap, pending} !== '0) begin
         n_err++;
         $display("FAIL async_reset: got %h want 0", {phase, tick, wrap, pending});
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         drive(1, 0, 0, 0);
         n_chk++;
         if ({phase, tick, wrap, pending} !== exp_vec()) begin
            n_err++;
            $display("FAIL post_reset c%0d: got %h want %h", i, {phase, tick, wrap, pending}, exp_vec());
         end
         if (i == 4) begin
            n_chk++;
            if (phase !== 10'd2) begin
               n_err++;
               $display("FAIL post_reset_phase: got %0d want 2", phase);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_default();
      test_en_low_update();
      test_midperiod_update();
      test_update_on_tc();
      test_invalid_code();
      test_en_pause();
      test_random();
      test_reset_pending();
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/ddfs_phase_accumulator.md
# ddfs_phase_accumulator

Prescaled phase accumulator for the DDFS path. Consumes the frequency word `fw` and decade prescale select `freq_control` produced by the frequency converter. Advances a phase register at a prescaled rate and emits the phase as a waveform-LUT address together with tick and wrap strobes. Parameter changes are staged and applied only on a prescaler boundary, so the output phase stays continuous.

## Interface
- `ACC_WIDTH`, 10: phase accumulator width; one output period = 2^ACC_WIDTH phase units.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  run enable; when low, the prescaler and phase are frozen.
- `fw`  in  7  frequency word; the phase step is `fw`+1 (range 1..128).
- `freq_control`  in  3  prescale select: 0→÷2, 1→÷10, 2→÷100, 3→÷1000, 4→÷10000, 5→÷100000, 6→÷1000000, 7→÷2 (invalid code, treated as 0).
- `update`  in  1  one-cycle strobe that captures `fw`/`freq_control` into shadow registers.
- `phase`  out  ACC_WIDTH  registered accumulator value (LUT address).
- `tick`  out  1  registered; high for one cycle when `phase` has just advanced.
- `wrap`  out  1  registered; high for one cycle when the last advance carried out of ACC_WIDTH (start of output period).
- `pending`  out  1  registered; shadow values not yet applied.

## Operation
- Registers:
  - active step `a_fw`/`a_fc`;
  - shadow `s_fw`/`s_fc`;
  - 20-bit prescale counter `pc`;
  - `phase`, `tick`, `wrap`, `pending`.
- Divide ratio N is decoded from `a_fc`. `pc` counts 0..N-1. Terminal count TC = `en` && (`pc` == N-1).
- On TC edge:
  - `pc`←0;
  - `phase`←(`phase` + `a_fw` + 1) mod 2^ACC_WIDTH, with the carry-out driving `wrap`;
  - `tick`←1.
- On an en edge without TC: `pc`←`pc`+1, `tick`←0, `wrap`←0.
- When `en` is low: `pc` and `phase` hold; `tick` and `wrap` are 0.
- Update path:
  - `update` high (not on a TC edge, `en` high): `s_*`←inputs, `pending`←1. A repeated `update` overwrites the shadow; the last one wins.
  - On a TC edge with `pending`=1: `a_*`←`s_*`, `pending`←0. The step applied at that same edge is the old `a_fw`; the new N governs the next period, and `pc` restarts at 0.
  - `update` coincident with a TC edge: inputs bypass the shadow straight into `a_*`, and `pending`←0. The old step is still used for the advance at that edge.
  - `en` low: `update` loads `a_*` directly. Any pending shadow is applied on the first edge with `en` low. `pending`←0 and `pc`←0.
- Arithmetic:
  - The step add is ACC_WIDTH+1 bits wide; the MSB is the wrap.
  - `pc` is wide enough for 999999.
  - There is no saturation.
- Output frequency = f_clk·(`fw`+1) / (N·2^ACC_WIDTH).

## Timing
- Reset (async assert, sampled release) sets:
  - `phase`=0, `tick`=0, `wrap`=0, `pending`=0;
  - `pc`=0;
  - `a_fw`=0, `a_fc`=0, `s_fw`=0, `s_fc`=0 (÷2, step 1).
- After reset release with `en` high, the first `tick` appears on the 2nd rising edge.
- `tick`, `wrap` and the new `phase` value all become visible after the same edge. `wrap` is never high without `tick`.
- `update`→`pending` latency: 1 clock.
- Apply latency: ≤ N_old clocks after `update` when `en` is high, i.e. at the next TC.
- Reset asserted mid-period or with `pending`=1 discards everything. There are no partial updates.
- `en` deassertion mid-period keeps `pc`. Re-enabling continues the count, with no extra or lost tick.

## Test plan
- Reset, `en`=1, defaults (÷2, step 1) → `tick` every 2 clocks, `phase` 1,2,3…; `wrap` with `phase`=0 at tick 1024 (clock 2048).
- `en`=0; `update` with `fw`=127, `freq_control`=1 → `pending` stays 0, applied immediately. `en`=1 → `tick` every 10 clocks, phase 128,256,…; `wrap` every 8th tick (80 clocks).
- Running ÷10 step 1. `update` (`fw`=3, `freq_control`=0) at `pc`=4 → `pending`=1 for 5 clocks. The next tick still adds 1. After that, ticks come every 2 clocks adding 4, and `pending`=0.
- `update` asserted exactly on a TC edge (÷2, new `fw`=9) → that advance adds 1, the following advance adds 10, and `pending` never rises.
- `freq_control`=7, `fw`=0 loaded → behaves as ÷2, step 1.
- Assert `rst` mid-period with `pending`=1 → all outputs 0 immediately. After release, default ÷2 step-1 behaviour; the shadow is lost.
